// File: rtl/mant_multi_tracker_if.sv
// mant_multi_tracker_if
//   Request/status bundle for the multi-channel maintenance tracker.
//   master : drives m (per-channel request), sel (count select), clr (counter clear)
//   slave  : drives busy, done_pulse (per channel), count (selected), total (sum)
interface mant_multi_tracker_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8,
   parameter int SW    = 2
);
   logic [N_CH-1:0]       m;
   logic [SW-1:0]         sel;
   logic                  clr;
   logic [N_CH-1:0]       busy;
   logic [N_CH-1:0]       done_pulse;
   logic [CNT_W-1:0]      count;
   logic [CNT_W+SW-1:0]   total;

   modport master (output m, sel, clr, input busy, done_pulse, count, total);
   modport slave  (input m, sel, clr, output busy, done_pulse, count, total);
endinterface

// File: rtl/mant_multi_tracker.sv
// mant_multi_tracker
//   N_CH independent maintenance trackers. Each channel must see its request
//   held for MAINT_CYCLES+1 consecutive edges to log one completed period;
//   releasing early aborts. Counters saturate or wrap (SATURATE), and clr
//   zeroes all counters synchronously.
//   Ports: clk, rst (async, active low), bus (slave modport):
//     m, sel, clr in; busy, done_pulse, count, total out.
module mant_multi_tracker #(
   parameter int N_CH         = 4,
   parameter int CNT_W        = 8,
   parameter int T_W          = 16,
   parameter int MAINT_CYCLES = 50,
   parameter bit SATURATE     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   mant_multi_tracker_if.slave   bus
);
   localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TOTW = CNT_W + SW;
   localparam logic [T_W-1:0]   T_LAST = T_W'(MAINT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAINT = 2'd1, S_HOLD = 2'd2} state_t;

   logic [N_CH-1:0][CNT_W-1:0] w_cnt;
   logic [N_CH-1:0]            w_busy;
   logic [N_CH-1:0]            w_done;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           r_state, w_state_nxt;
      logic [T_W-1:0]   r_tmr, w_tmr_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic             r_done, w_inc;

      always_comb begin
         w_state_nxt = r_state;
         w_tmr_nxt   = r_tmr;
         w_inc       = 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.m[g]) begin
                  w_state_nxt = S_MAINT;
                  w_tmr_nxt   = '0;
               end
            end
            S_MAINT: begin
               if (!bus.m[g]) begin
                  // early release: partial period is discarded
                  w_state_nxt = S_IDLE;
                  w_tmr_nxt   = '0;
               end else if (r_tmr == T_LAST) begin
                  w_state_nxt = S_HOLD;
                  w_inc       = 1'b1;
               end else begin
                  w_tmr_nxt = r_tmr + T_W'(1);
               end
            end
            S_HOLD: begin
               // a held request counts once; must drop before re-arming
               if (!bus.m[g]) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_done  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_done  <= w_inc;
         end
      end

      // clr beats a simultaneous completion; that completion is dropped
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)             r_cnt <= '0;
         else if (bus.clr)     r_cnt <= '0;
         else if (w_inc) begin
            if (r_cnt == C_MAX) r_cnt <= SATURATE ? C_MAX : '0;
            else                r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      assign w_cnt[g]  = r_cnt;
      assign w_busy[g] = (r_state == S_MAINT);
      assign w_done[g] = r_done;
   end

   // select table padded to 2^SW so out-of-range sel reads zero
   logic [CNT_W-1:0] w_pad [2**SW];
   logic [TOTW-1:0]  w_sum;
   logic [CNT_W-1:0] r_count;
   logic [TOTW-1:0]  r_total;

   always_comb begin
      w_pad = '{default: '0};
      w_sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_pad[i] = w_cnt[i];
         w_sum    = w_sum + TOTW'(w_cnt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_total <= '0;
      end else begin
         r_count <= w_pad[bus.sel];
         r_total <= w_sum;
      end
   end

   assign bus.busy       = w_busy;
   assign bus.done_pulse = w_done;
   assign bus.count      = r_count;
   assign bus.total      = r_total;
endmodule

// File: doc/mant_multi_tracker.md
# mant_multi_tracker

- Parametrised, multi-channel successor of the single-channel maintenance counter.
- Tracks `N_CH` independent maintenance requests; each channel runs its own FSM and a `MAINT_CYCLES` timer, and counts completed maintenance periods in a `CNT_W`-bit counter.
- Adds abort-on-release, a saturate-or-wrap counter mode, a synchronous count clear, per-channel busy/done status, a selectable per-channel count and a registered all-channel total.
- Sits between the request inputs and the display/register stage of the top level.

## Interface

Parameters:
- `N_CH`, 4: number of channels, ≥1.
- `CNT_W`, 8: completed-maintenance counter width per channel.
- `T_W`, 16: timer width.
- `MAINT_CYCLES`, 50: cycles of held request per completed maintenance; 2 ≤ value < 2^T_W.
- `SATURATE`, 1: 1 = counters stick at 2^CNT_W−1; 0 = counters wrap to 0.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-low reset.
- `m` in, N_CH: per-channel maintenance request level, synchronous to `clk`.
- `sel` in, SW = max(1,$clog2(N_CH)): channel whose count drives `count`.
- `clr` in, 1: synchronous clear of all channel counters.
- `busy` out, N_CH: channel in MAINT state.
- `done_pulse` out, N_CH: one-cycle pulse per completed maintenance.
- `count` out, CNT_W: registered count of channel `sel`.
- `total` out, CNT_W+SW: registered sum of all channel counts.

## Operation

Per-channel FSM states:
- **IDLE**, entered on reset.
  - `m`=1 → MAINT; timer ← 0.
  - `m`=0 → stay.
- **MAINT**
  - `m`=0 → IDLE; timer ← 0; no count (abort).
  - `m`=1 and timer < MAINT_CYCLES−1 → timer++.
  - `m`=1 and timer == MAINT_CYCLES−1 → HOLD; counter increments; `done_pulse` set for the next cycle.
- **HOLD**
  - `m`=0 → IDLE.
  - `m`=1 → stay.
  - A continuously held request therefore counts exactly once.

Counters and clear:
- Counter increment is SATURATE-dependent: at 2^CNT_W−1 it either holds or wraps to 0.
- `clr`=1 zeroes all counters on that edge and wins over a simultaneous increment; that completion is lost.
- `clr` does not touch FSMs, timers, `busy` or `done_pulse`.

Outputs:
- `busy` is decoded from the state register (MAINT) and is itself a register-derived signal.
- `count` ← counter[`sel`] every edge.
- `sel` ≥ N_CH (non-power-of-two N_CH) drives `count` ← 0.
- `total` ← sum of all counters every edge, at full width with no overflow.
- Channels are fully independent. Simultaneous completions on several channels all count in the same cycle.

Reset:
- `rst` low clears immediately, regardless of clock: all FSMs to IDLE, timers, counters, `busy`, `done_pulse`, `count` and `total` to 0.
- Reset mid-MAINT discards the partial period.
- After `rst` rises, a channel whose `m` is already high starts MAINT on the first edge.

## Timing

- Let E0 be the edge at which IDLE samples `m`=1.
- `busy` is high in the cycles after edges E0 … E(M−1), i.e. M = MAINT_CYCLES cycles.
- At E(M), if `m` is still 1: state becomes HOLD, counter is incremented, and `done_pulse` is high for exactly one cycle after E(M).
- `count` and `total` reflect the new value one edge later, after E(M+1).
- `m` low at any edge E1 … E(M) aborts. `m` must be high at M+1 consecutive edges (E0 … E(M)) for a count.
- Minimum spacing between two counts on one channel is M+2 edges: one edge with `m`=0 in HOLD (HOLD→IDLE), then a new request.
- A `sel` change shows on `count` after one edge.
- `clr` shows on `count`/`total` after two edges: counter, then output register.

## Test plan

- **Reset:** `rst` low mid-operation → all outputs 0 immediately with no clock edge; MAINT channel returns to IDLE; counters 0.
- **Single channel, defaults (MAINT_CYCLES=50):** hold `m[0]`=1 for 60 cycles → `busy[0]` high 50 cycles; one `done_pulse[0]`; `count`=1 with `sel`=0; `total`=1; still 1 after 60 cycles.
- **Abort:** `m[1]` high for 50 sampled edges, then low at E50 → no `done_pulse`, count stays 0. Re-request held 51 edges → count 1.
- **Simultaneous completions:** all 4 channels requested on the same edge and held → four `done_pulse` bits in the same cycle; `total`=4 two edges after completion.
- **Saturation:** CNT_W=2, MAINT_CYCLES=2, 5 complete requests on channel 0 → `count`=3 with SATURATE=1, `count`=1 with SATURATE=0.
- **Clear collision:** `clr` asserted on the completion edge of channel 2 → counter 0, `done_pulse[2]` still pulses, `total` drops to 0.
